// File: rtl/tile_scheduler.sv
// Tile scheduler: latches one triangle, finds its screen-clamped tile bounding box and
// hands the triangle to the tile processor once per covered tile, row-major.
package tile_scheduler_pkg;
  localparam int FX_TOTAL_BITS = 24;
  localparam int FX_FRAC_BITS  = 8;

  typedef struct packed {
    logic signed [FX_TOTAL_BITS-1:0] x;
    logic signed [FX_TOTAL_BITS-1:0] y;
    logic signed [FX_TOTAL_BITS-1:0] z;
  } coord_3d_t;

  typedef struct packed {
    logic [31:0] color;
    logic [15:0] tile_x;
    logic [15:0] tile_y;
  } metadata_t;
endpackage

module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int TILE_SHIFT = 4,
  parameter int TILES_X    = 40,
  parameter int TILES_Y    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_in,
  output logic        rdy_in,
  input  coord_3d_t   v0,
  input  coord_3d_t   v1,
  input  coord_3d_t   v2,
  input  metadata_t   in_metadata,
  output logic        tp_vld,
  input  logic        tp_rdy,
  output coord_3d_t   tp_v0,
  output coord_3d_t   tp_v1,
  output coord_3d_t   tp_v2,
  output metadata_t   tp_metadata,
  output logic [15:0] tile_count,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_BBOX, S_ISSUE, S_DONE} state_t;
  typedef logic signed [FX_TOTAL_BITS-1:0] tcoord_t;

  localparam int      SH     = FX_FRAC_BITS + TILE_SHIFT;
  localparam tcoord_t LAST_X = FX_TOTAL_BITS'(TILES_X - 1);
  localparam tcoord_t LAST_Y = FX_TOTAL_BITS'(TILES_Y - 1);

  state_t      r_state;
  logic        r_rdy;
  logic        r_tpVld;
  logic        r_done;
  logic [15:0] r_count;
  coord_3d_t   r_v0, r_v1, r_v2;
  metadata_t   r_meta;
  logic [15:0] r_minX, r_maxX, r_minY, r_maxY;

  tcoord_t w_tx0, w_tx1, w_tx2, w_ty0, w_ty1, w_ty2;
  tcoord_t w_minTx, w_maxTx, w_minTy, w_maxTy;
  tcoord_t w_clMinX, w_clMaxX, w_clMinY, w_clMaxY;
  logic    w_offscreen;

  function automatic tcoord_t min3(input tcoord_t a, input tcoord_t b, input tcoord_t c);
    tcoord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic tcoord_t max3(input tcoord_t a, input tcoord_t b, input tcoord_t c);
    tcoord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Fixed point -> pixel -> tile is a single arithmetic shift, floor semantics for negatives.
  assign w_tx0 = $signed(r_v0.x) >>> SH;
  assign w_tx1 = $signed(r_v1.x) >>> SH;
  assign w_tx2 = $signed(r_v2.x) >>> SH;
  assign w_ty0 = $signed(r_v0.y) >>> SH;
  assign w_ty1 = $signed(r_v1.y) >>> SH;
  assign w_ty2 = $signed(r_v2.y) >>> SH;

  assign w_minTx = min3(w_tx0, w_tx1, w_tx2);
  assign w_maxTx = max3(w_tx0, w_tx1, w_tx2);
  assign w_minTy = min3(w_ty0, w_ty1, w_ty2);
  assign w_maxTy = max3(w_ty0, w_ty1, w_ty2);

  assign w_offscreen = (w_maxTx < 0) || (w_minTx > LAST_X) ||
                       (w_maxTy < 0) || (w_minTy > LAST_Y);

  assign w_clMinX = (w_minTx < 0) ? '0 : w_minTx;
  assign w_clMaxX = (w_maxTx > LAST_X) ? LAST_X : w_maxTx;
  assign w_clMinY = (w_minTy < 0) ? '0 : w_minTy;
  assign w_clMaxY = (w_maxTy > LAST_Y) ? LAST_Y : w_maxTy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b1;
      r_tpVld <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_v0    <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_meta  <= '0;
      r_minX  <= '0;
      r_maxX  <= '0;
      r_minY  <= '0;
      r_maxY  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (vld_in && r_rdy) begin
            r_v0    <= v0;
            r_v1    <= v1;
            r_v2    <= v2;
            r_meta  <= in_metadata;
            r_count <= '0;
            r_rdy   <= 1'b0;
            r_state <= S_BBOX;
          end
        end
        S_BBOX: begin
          if (w_offscreen) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_minX        <= 16'(w_clMinX);
            r_maxX        <= 16'(w_clMaxX);
            r_minY        <= 16'(w_clMinY);
            r_maxY        <= 16'(w_clMaxY);
            r_meta.tile_x <= 16'(w_clMinX);
            r_meta.tile_y <= 16'(w_clMinY);
            r_tpVld       <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The current tile lives in r_meta, so a stalled job holds every tp_* output.
          if (tp_rdy) begin
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            if (r_meta.tile_x < r_maxX) begin
              r_meta.tile_x <= r_meta.tile_x + 16'd1;
            end else if (r_meta.tile_y < r_maxY) begin
              r_meta.tile_x <= r_minX;
              r_meta.tile_y <= r_meta.tile_y + 16'd1;
            end else begin
              r_tpVld <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdy_in      = r_rdy;
  assign tp_vld      = r_tpVld;
  assign tp_v0       = r_v0;
  assign tp_v1       = r_v1;
  assign tp_v2       = r_v2;
  assign tp_metadata = r_meta;
  assign tile_count  = r_count;
  assign done        = r_done;

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: an independent bbox model fills a queue of
// expected tile jobs that is drained as the scheduler hands jobs off.
module tb_tile_scheduler;
  import tile_scheduler_pkg::*;

  typedef struct {
    int tx;
    int ty;
  } job_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_in = 1'b0;
  logic        rdy_in;
  coord_3d_t   v0 = '0, v1 = '0, v2 = '0;
  metadata_t   in_metadata = '0;
  logic        tp_vld;
  logic        tp_rdy = 1'b1;
  coord_3d_t   tp_v0, tp_v1, tp_v2;
  metadata_t   tp_metadata;
  logic [15:0] tile_count;
  logic        done;

  int          nTests = 0;
  int          nFail  = 0;
  job_t        expQ[$];
  coord_3d_t   expV0, expV1, expV2;
  logic [31:0] expColor;

  tile_scheduler dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_in(rdy_in),
    .v0(v0), .v1(v1), .v2(v2), .in_metadata(in_metadata),
    .tp_vld(tp_vld), .tp_rdy(tp_rdy),
    .tp_v0(tp_v0), .tp_v1(tp_v1), .tp_v2(tp_v2), .tp_metadata(tp_metadata),
    .tile_count(tile_count), .done(done)
  );

  always #5 clk = ~clk;

  function automatic coord_3d_t mkCoord(input int px, input int py);
    coord_3d_t c;
    c.x = FX_TOTAL_BITS'(px * 256);
    c.y = FX_TOTAL_BITS'(py * 256);
    c.z = FX_TOTAL_BITS'(7 * 256);
    return c;
  endfunction

  // Floor division by the 16-pixel tile edge, written with integer division.
  function automatic int tileOf(input int p);
    return (p >= 0) ? p / 16 : -((15 - p) / 16);
  endfunction

  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  task automatic pushModel(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
    int x0, x1, y0, y1;
    job_t j;
    x0 = imin3(tileOf(ax), tileOf(bx), tileOf(cx));
    x1 = imax3(tileOf(ax), tileOf(bx), tileOf(cx));
    y0 = imin3(tileOf(ay), tileOf(by), tileOf(cy));
    y1 = imax3(tileOf(ay), tileOf(by), tileOf(cy));
    if (x1 < 0 || x0 > 39 || y1 < 0 || y0 > 29) return;
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > 39) x1 = 39;
    if (y1 > 29) y1 = 29;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        j.tx = x;
        j.ty = y;
        expQ.push_back(j);
      end
    end
  endtask

  task automatic driveTriangle(input int ax, input int ay, input int bx, input int by,
                               input int cx, input int cy, input logic [31:0] color);
    int guard = 0;
    @(negedge clk);
    while (!rdy_in && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    nTests++;
    if (rdy_in !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL accept_ready: rdy_in=%b required 1", rdy_in);
    end
    expV0 = mkCoord(ax, ay);
    expV1 = mkCoord(bx, by);
    expV2 = mkCoord(cx, cy);
    expColor = color;
    v0 = expV0;
    v1 = expV1;
    v2 = expV2;
    in_metadata = '{color: color, tile_x: 16'hABCD, tile_y: 16'h1234};
    vld_in = 1'b1;
    tp_rdy = 1'b1;
    @(posedge clk);
    #1;
    vld_in = 1'b0;
    pushModel(ax, ay, bx, by, cx, cy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nTests++;
    if (rdy_in !== 1'b1 || tp_vld !== 1'b0 || done !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_ctrl: rdy_in=%b tp_vld=%b done=%b required 1 0 0", rdy_in, tp_vld, done);
    end
    nTests++;
    if (tile_count !== 16'd0 || tp_v0 !== '0 || tp_v2 !== '0 || tp_metadata !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_data: tile_count=%0d tp_v0=%h tp_metadata=%h required all zero",
               tile_count, tp_v0, tp_metadata);
    end
    rst = 1'b0;
  endtask

  // Runs one triangle to completion, optionally stalling tp_rdy on one job.
  task automatic test_tile_walk(input string name, input int ax, input int ay, input int bx,
                                input int by, input int cx, input int cy,
                                input logic [31:0] color, input int stallJob, input int stallCycles);
    int cyc = 0, jobIdx = 0, stallLeft = stallCycles, lastHs = 0, firstVld = -1, total;
    bit sawDone = 0, prevPending = 0;
    driveTriangle(ax, ay, bx, by, cx, cy, color);
    total = expQ.size();
    while (!sawDone && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (jobIdx == stallJob && stallLeft > 0) begin
        tp_rdy = 1'b0;
        stallLeft--;
      end else begin
        tp_rdy = 1'b1;
      end
      if (prevPending) begin
        nTests++;
        if (tp_vld !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL %s vld_hold: tp_vld=%b required 1 (cycle %0d)", name, tp_vld, cyc);
        end
      end
      prevPending = 0;
      if (tp_vld === 1'b1) begin
        if (firstVld < 0) begin
          firstVld = cyc;
          nTests++;
          if (cyc != 2) begin
            nFail++;
            $display("[TB] FAIL %s first_latency: cycle %0d required 2", name, cyc);
          end
        end
        nTests++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL %s extra_job: tile (%0d,%0d) issued, required none", name,
                   tp_metadata.tile_x, tp_metadata.tile_y);
        end else begin
          nTests++;
          if (tp_metadata.tile_x !== 16'(expQ[0].tx) || tp_metadata.tile_y !== 16'(expQ[0].ty)) begin
            nFail++;
            $display("[TB] FAIL %s tile: got (%0d,%0d) required (%0d,%0d)", name,
                     tp_metadata.tile_x, tp_metadata.tile_y, expQ[0].tx, expQ[0].ty);
          end
          nTests++;
          if (tp_metadata.color !== expColor) begin
            nFail++;
            $display("[TB] FAIL %s color: got %h required %h", name, tp_metadata.color, expColor);
          end
          nTests++;
          if (tp_v0 !== expV0 || tp_v1 !== expV1 || tp_v2 !== expV2) begin
            nFail++;
            $display("[TB] FAIL %s vertices: got %h/%h/%h required %h/%h/%h", name,
                     tp_v0, tp_v1, tp_v2, expV0, expV1, expV2);
          end
          if (tp_rdy) begin
            void'(expQ.pop_front());
            jobIdx++;
            lastHs = cyc;
          end else begin
            prevPending = 1;
          end
        end
      end
      if (done === 1'b1) begin
        sawDone = 1;
        nTests++;
        if (expQ.size() != 0) begin
          nFail++;
          $display("[TB] FAIL %s jobs_left: %0d remaining required 0", name, expQ.size());
        end
        nTests++;
        if (tile_count !== 16'(total)) begin
          nFail++;
          $display("[TB] FAIL %s tile_count: got %0d required %0d", name, tile_count, total);
        end
        nTests++;
        if (cyc != ((total == 0) ? 2 : lastHs + 1)) begin
          nFail++;
          $display("[TB] FAIL %s done_timing: cycle %0d required %0d", name, cyc,
                   (total == 0) ? 2 : lastHs + 1);
        end
      end
    end
    if (!sawDone) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL %s timeout: done not seen in %0d cycles", name, cyc);
    end
    @(negedge clk);
    nTests++;
    if (done !== 1'b0 || rdy_in !== 1'b1 || tp_vld !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL %s after_done: done=%b rdy_in=%b tp_vld=%b required 0 1 0", name,
               done, rdy_in, tp_vld);
    end
    expQ.delete();
  endtask

  task automatic test_reset_mid();
    int hs = 0, cyc = 0;
    driveTriangle(5, 5, 40, 12, 20, 20, 32'h22);
    tp_rdy = 1'b1;
    while (hs < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (tp_vld === 1'b1) hs++;
    end
    @(negedge clk);
    nTests++;
    if (tp_vld !== 1'b1 || tp_metadata.tile_x !== 16'd2 || tp_metadata.tile_y !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL rst_mid third_job: tp_vld=%b tile (%0d,%0d) required 1 (2,0)",
               tp_vld, tp_metadata.tile_x, tp_metadata.tile_y);
    end
    rst = 1'b1;
    @(negedge clk);
    nTests++;
    if (tp_vld !== 1'b0 || rdy_in !== 1'b1 || done !== 1'b0 || tile_count !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL rst_mid state: tp_vld=%b rdy_in=%b done=%b tile_count=%0d required 0 1 0 0",
               tp_vld, rdy_in, done, tile_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nTests++;
      if (done !== 1'b0 || tp_vld !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL rst_mid quiet: done=%b tp_vld=%b required 0 0", done, tp_vld);
      end
    end
    expQ.delete();
    test_tile_walk("after_reset", 1, 14, 7, 2, 12, 15, 32'h5, -1, 0);
  endtask

  initial begin
    test_reset();
    test_tile_walk("single_tile", 1, 14, 7, 2, 12, 15, 32'h1, -1, 0);
    test_tile_walk("multi_tile", 5, 5, 40, 12, 20, 20, 32'hC0FFEE, -1, 0);
    test_tile_walk("stall", 5, 5, 40, 12, 20, 20, 32'h33, 1, 3);
    test_tile_walk("offscreen", -5, 3, -30, 10, -1, 20, 32'h44, -1, 0);
    test_tile_walk("clamp", -20, 0, 700, 5, 300, 10, 32'h55, -1, 0);
    test_tile_walk("back_to_back", 100, 100, 130, 90, 120, 140, 32'h66, 2, 1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
